// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and 8N1 frame constants shared by the uart_io files
package uart_pkg;
  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP, T_DONE} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {Q_IDLE, Q_SEND, Q_RECV} req_state_t;
endpackage

// File: rtl/uart_io_if.sv
// uart_io_if: request/response bundle between the core control FSM and uart_io
interface uart_io_if;
  logic       uart_go;
  logic       rors;
  logic [7:0] tx_data;
  logic       uart_done;
  logic [7:0] rx_data;
  modport master (output uart_go, rors, tx_data, input uart_done, rx_data);
  modport slave  (input uart_go, rors, tx_data, output uart_done, rx_data);
endinterface

// File: rtl/uart_rxbuf.sv
// uart_rxbuf: receive byte buffer; circular FIFO when UART_RXFIFO_EN is defined, else a single holding register
module uart_rxbuf #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
`ifdef UART_RXFIFO_EN
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW = DEPTH_LOG2 + 1;
  logic [7:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic do_push;
  // extra pointer MSB tells full from empty; a pop frees the slot a same-cycle push needs
  always_comb begin
    empty = wp_q == rp_q;
    full = (wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2]) && (wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0]);
    do_push = push && (!full || pop);
    wp_d = wp_q + PW'(do_push);
    rp_d = rp_q + PW'(pop && !empty);
    dout = mem_q[rp_q[DEPTH_LOG2-1:0]];
  end
  // storage array, no reset needed since pointers gate every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[DEPTH_LOG2-1:0]] <= din;
  end
  // pointer registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
`else
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  // a push while holding is dropped unless the held byte leaves in the same cycle
  always_comb begin
    valid_d = push || (valid_q && !pop);
    data_d = (push && (!valid_q || pop)) ? din : data_q;
    full = valid_q;
    empty = !valid_q;
    dout = data_q;
  end
  // holding register with valid bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
`endif
endmodule

// File: rtl/uart_io.sv
// uart_io: byte UART front end for sendb/recvb; define UART_RXFIFO_EN for a receive FIFO instead of a holding register
module uart_io
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int RXFIFO_LOG2  = 4
) (
  input  logic     clk,
  input  logic     rstn,
  uart_io_if.slave bus,
  output logic     txd,
  input  logic     rxd,
  output logic     rx_overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);
  tx_state_t  tx_q, tx_d;
  rx_state_t  rx_q, rx_d;
  req_state_t req_q, req_d;
  logic [CW-1:0] txc_q, txc_d, rxc_q, rxc_d;
  logic [2:0] txb_q, txb_d, rxb_q, rxb_d, sync_q, sync_d;
  logic [7:0] txsh_q, txsh_d, rxsh_q, rxsh_d, rx_data_q, rx_data_d, buf_dout;
  logic push_q, push_d, ovr_q, ovr_d;
  logic tx_start, tx_bit_end, pop, buf_full, buf_empty;
  uart_rxbuf #(.DEPTH_LOG2(RXFIFO_LOG2)) u_rxbuf (
    .clk  (clk),
    .rstn (rstn),
    .push (push_q),
    .pop  (pop),
    .din  (rxsh_q),
    .dout (buf_dout),
    .full (buf_full),
    .empty(buf_empty)
  );
  // request arbitration: one outstanding send or receive, completion pulse, received byte latch
  always_comb begin
    req_d = req_q;
    rx_data_d = rx_data_q;
    ovr_d = ovr_q || (push_q && buf_full && !pop);
    tx_start = req_q == Q_IDLE && bus.uart_go && bus.rors;
    pop = req_q == Q_RECV && !buf_empty;
    if (req_q == Q_IDLE && bus.uart_go) req_d = bus.rors ? Q_SEND : Q_RECV;
    if (req_q == Q_SEND && tx_q == T_DONE) req_d = Q_IDLE;
    if (pop) begin
      req_d = Q_IDLE;
      rx_data_d = buf_dout;
    end
    bus.uart_done = (req_q == Q_SEND && tx_q == T_DONE) || pop;
  end
  assign bus.rx_data = rx_data_q;
  assign rx_overrun = ovr_q;
  // transmit sequencer: start bit, LSB-first data, stop bit, then one done cycle
  always_comb begin
    tx_d = tx_q;
    txb_d = txb_q;
    txsh_d = txsh_q;
    tx_bit_end = txc_q == BIT_LAST;
    txc_d = (tx_q inside {T_START, T_DATA, T_STOP}) && !tx_bit_end ? txc_q + CW'(1) : '0;
    case (tx_q)
      T_IDLE: if (tx_start) begin
        tx_d = T_START;
        txsh_d = bus.tx_data;
      end
      T_START: if (tx_bit_end) begin
        tx_d = T_DATA;
        txb_d = '0;
      end
      T_DATA: if (tx_bit_end) begin
        txsh_d = txsh_q >> 1;
        txb_d = txb_q + 3'd1;
        if (txb_q == IDX_LAST) tx_d = T_STOP;
      end
      T_STOP: if (tx_bit_end) tx_d = T_DONE;
      default: tx_d = T_IDLE;
    endcase
    txd = tx_q == T_START ? START_LVL : tx_q == T_DATA ? txsh_q[0] : STOP_LVL;
  end
  // receive sequencer: sync[1] is the synchronized line, sync[2] its previous value for edge detection
  always_comb begin
    sync_d = {sync_q[1:0], rxd};
    rx_d = rx_q;
    rxb_d = rxb_q;
    rxsh_d = rxsh_q;
    push_d = 1'b0;
    rxc_d = rx_q == R_IDLE ? '0 : rxc_q + CW'(1);
    case (rx_q)
      R_IDLE: if (sync_q[2] && !sync_q[1]) rx_d = R_START;
      R_START: if (rxc_q == HALF_LAST) begin
        rx_d = sync_q[1] != START_LVL ? R_IDLE : R_DATA;
        rxc_d = '0;
        rxb_d = '0;
      end
      R_DATA: if (rxc_q == BIT_LAST) begin
        rxc_d = '0;
        rxsh_d = {sync_q[1], rxsh_q[7:1]};
        rxb_d = rxb_q + 3'd1;
        if (rxb_q == IDX_LAST) rx_d = R_STOP;
      end
      default: if (rxc_q == BIT_LAST) begin
        rx_d = R_IDLE;
        push_d = sync_q[1] == STOP_LVL;
      end
    endcase
  end
  // all state registers; reset aborts frames in flight without keeping partial bytes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_q <= T_IDLE;
      txc_q <= '0;
      txb_q <= '0;
      txsh_q <= '0;
      sync_q <= '1;
      rx_q <= R_IDLE;
      rxc_q <= '0;
      rxb_q <= '0;
      rxsh_q <= '0;
      push_q <= 1'b0;
      req_q <= Q_IDLE;
      rx_data_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      tx_q <= tx_d;
      txc_q <= txc_d;
      txb_q <= txb_d;
      txsh_q <= txsh_d;
      sync_q <= sync_d;
      rx_q <= rx_d;
      rxc_q <= rxc_d;
      rxb_q <= rxb_d;
      rxsh_q <= rxsh_d;
      push_q <= push_d;
      req_q <= req_d;
      rx_data_q <= rx_data_d;
      ovr_q <= ovr_d;
    end
  end
endmodule

// File: doc/uart_io.md
# uart_io

Byte-level UART front end serving the multicycle core's `sendb`/`recvb` instructions. It consumes the control FSM's `uart_go`/`rors` request and returns a one-cycle `uart_done`. It serializes transmit bytes onto `txd`, deserializes `rxd` into a receive buffer, and holds the received byte for the register-file write in the following state.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `RXFIFO_LOG2`, default 4: log2 of receive FIFO depth (used only with `UART_RXFIFO_EN`).

Ports:
- `clk`, in, 1: single clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `uart_go`, in, 1: one-cycle request pulse.
- `rors`, in, 1: request kind, sampled with `uart_go`; 1 = send, 0 = receive.
- `tx_data`, in, 8: byte to send, sampled when `uart_go & rors`.
- `uart_done`, out, 1: one-cycle completion pulse.
- `rx_data`, out, 8: received byte. Valid from the `uart_done` of a receive until the next receive completes.
- `txd`, out, 1: serial transmit line, idle high.
- `rxd`, in, 1: serial receive line, asynchronous.
- `rx_overrun`, out, 1: sticky flag, set when a received byte is dropped because the buffer is full.

## Operation
- Reset values: `txd`=1, `uart_done`=0, `rx_data`=0, `rx_overrun`=0. Buffer empty, all FSMs idle. Reset mid-frame aborts the frame immediately, with no partial byte kept.
- Frame format: 8N1. Start bit 0, data bits LSB first, stop bit 1.
- TX FSM states `T_IDLE → T_START → T_DATA → T_STOP → T_DONE → T_IDLE`.
  - Bit counter 0..7 runs in `T_DATA`.
  - Cycle counter runs 0..`CLKS_PER_BIT`-1 in each bit state.
- RX FSM states `R_IDLE → R_START → R_DATA → R_STOP → R_IDLE`.
  - `rxd` passes through a 2-flop synchronizer before use.
  - `R_IDLE`: a synchronized 1→0 edge enters `R_START`.
  - `R_START`: wait `CLKS_PER_BIT/2` cycles, then re-sample. If the line is high, it is a false start; return to `R_IDLE`.
  - `R_DATA`: sample each data bit every `CLKS_PER_BIT` cycles.
  - `R_STOP`: if the stop sample is 1, push the byte. If it is 0 (framing error), discard the byte and return to `R_IDLE`.
- Request FSM states `Q_IDLE`, `Q_SEND`, `Q_RECV`.
  - Send: `uart_go & rors` in `Q_IDLE` latches `tx_data` and starts TX. `uart_done` pulses in the `T_DONE` cycle.
  - Receive: `uart_go & ~rors` enters `Q_RECV`. In the first `Q_RECV` cycle with the buffer non-empty, pop the head into `rx_data` and pulse `uart_done` in that same cycle.
  - `uart_go` in any state other than `Q_IDLE` is ignored.
- The receive path runs continuously and independently of requests. Bytes arriving with no receive pending are buffered.
- Buffer full at push time: the byte is dropped and `rx_overrun` is set. A simultaneous pop and push when full accepts the push.
- Empty buffer at pop time: cannot occur, since a pop happens only on the non-empty condition.

## Timing
- Send: `uart_go` at cycle 0.
  - `txd` start bit covers cycles 1..B, where B = `CLKS_PER_BIT`.
  - Data bit k covers cycles (k+1)B+1..(k+2)B.
  - Stop bit covers cycles 9B+1..10B.
  - `uart_done`=1 in cycle 10B+1 only.
- Receive with buffer non-empty at the go cycle: `uart_done` in cycle 1.
- Receive with buffer empty: `uart_done` one cycle after the push that makes it non-empty. Push occurs in the cycle after the stop-bit sample.
- `rx_data` is registered. It updates in the `uart_done` cycle and is stable in the following cycle, which is the write-back state.
- TX and RX are full duplex; neither blocks the other.

## Configuration
- `UART_RXFIFO_EN` defined: receive buffer is a 2^`RXFIFO_LOG2`-entry circular FIFO. It has wrapping read/write pointers plus an extra MSB for the full/empty distinction.
- Not defined: receive buffer is a single holding register with a valid bit. `RXFIFO_LOG2` is ignored. A second byte arriving while valid is dropped and sets `rx_overrun`.

## Structure
- Package `uart_pkg`:
  - `tx_state_t`, `rx_state_t`, `req_state_t` enums.
  - Frame constants: `DATA_BITS`=8, start/stop levels.
- Sub-module `uart_rxbuf`: push/pop/full/empty interface, implementing either the FIFO or the holding register under `UART_RXFIFO_EN`.
- Top `uart_io` contains the synchronizer, the TX/RX/request FSMs and the counters.

## Test plan
All scenarios run with B=`CLKS_PER_BIT`=8.
- Send 0xA5: `txd` sequence 0,1,0,1,0,0,1,0,1,1, each 8 cycles. `uart_done` pulses at cycle 81 only.
- Drive frame 0x3C on `rxd`, then receive request: `uart_done` 1 cycle after go, `rx_data`=0x3C held ≥2 cycles.
- Receive request first, frame 0x81 arrives 200 cycles later: `uart_done` one cycle after the push, `rx_data`=0x81, no earlier pulse.
- 3-cycle low glitch on idle `rxd`: no push, buffer stays empty. Frame with stop bit 0: byte discarded.
- With `UART_RXFIFO_EN` and `RXFIFO_LOG2`=2, push 5 bytes 0x01..0x05 with no receives: `rx_overrun`=1, four receives return 0x01..0x04. Without the macro, push 2 bytes: `rx_overrun`=1, a receive returns 0x01.
- Deassert `rstn` mid-send at cycle 30: `txd`=1 immediately, no `uart_done`. A new send after reset completes normally.
